// File: rtl/pipe_perf_mon.sv
// Run-control and performance monitor: halt detect, drain, frozen counters, select readout.
// Optional watchdog (RUN-state idle timeout) compiled in with PERF_MON_WATCHDOG_EN.

module pipe_perf_mon_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
      o_ovf <= 1'b0;
    end else if (i_inc) begin
      if (&o_cnt) o_ovf <= 1'b1;
      else        o_cnt <= o_cnt + 1'b1;
    end
  end
endmodule

module pipe_perf_mon #(
  parameter int          CNT_W     = 32,
  parameter int          NUM_EVT   = 4,
  parameter logic [31:0] HALT_INSN = 32'h11111111,
  parameter int          DRAIN_CYC = 4,
  parameter int          WDOG_CYC  = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic                         i_clear,
  input  logic                         i_insn_vld,
  input  logic [31:0]                  i_if_instr,
  input  logic [NUM_EVT-1:0]           i_evt,
  input  logic [$clog2(NUM_EVT+2)-1:0] i_rd_sel,
  output logic [CNT_W-1:0]             o_rd_data,
  output logic [NUM_EVT+1:0]           o_ovf,
  output logic                         o_running,
  output logic                         o_done,
  output logic                         o_timeout
);
  localparam int NCNT  = NUM_EVT + 2;
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic             clr, halt, cnt_en, drain_last, wdog_fire;
  logic [DRN_W-1:0] drain_cnt;
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0][CNT_W-1:0] cnt;

  assign clr        = i_rst | i_clear;
  assign halt       = (i_if_instr == HALT_INSN);
  assign cnt_en     = (state == S_RUN) || (state == S_DRAIN);
  assign drain_last = (drain_cnt == DRN_W'(DRAIN_CYC - 1));

`ifdef PERF_MON_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            timeout_q;

  // Halt in the limit cycle wins, so the watchdog only fires on a non-halt cycle.
  assign wdog_fire = (state == S_RUN) && !i_insn_vld && !halt &&
                     (wdog_cnt == WD_W'(WDOG_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (clr) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_RUN) wdog_cnt <= i_insn_vld ? '0 : wdog_cnt + 1'b1;
      if (wdog_fire)      timeout_q <= 1'b1;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign wdog_fire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_enable) state_nxt = S_RUN;
      S_RUN:   if (halt) state_nxt = S_DRAIN;
               else if (wdog_fire) state_nxt = S_DONE;
      S_DRAIN: if (drain_last) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Drain counter idles at zero outside DRAIN so each drain starts fresh.
  always_ff @(posedge i_clk) begin
    if (clr || state != S_DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + 1'b1;
  end

  assign inc = {i_evt, i_insn_vld, 1'b1} & {NCNT{cnt_en}};

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    pipe_perf_mon_cnt #(.CNT_W(CNT_W)) u_cnt (
      .i_clk (i_clk),
      .i_rst (clr),
      .i_inc (inc[g]),
      .o_cnt (cnt[g]),
      .o_ovf (o_ovf[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (clr)                      o_rd_data <= '0;
    else if (int'(i_rd_sel) < NCNT) o_rd_data <= cnt[i_rd_sel];
    else                          o_rd_data <= '0;
  end

  assign o_running = cnt_en;
  assign o_done    = (state == S_DONE);
endmodule

// File: tb/tb_pipe_perf_mon.sv
// Scoreboard bench for pipe_perf_mon: default instance plus a CNT_W=4 / WDOG_CYC=8 instance.
// Watchdog scenario runs only when PERF_MON_WATCHDOG_EN is defined.
module tb_pipe_perf_mon;
  localparam int          NUM_EVT = 4;
  localparam logic [31:0] HALT    = 32'h11111111;
  localparam logic [31:0] NOP     = 32'h00000013;

  logic                 i_clk = 1'b0;
  logic                 i_rst, i_enable, i_clear, i_insn_vld;
  logic [31:0]          i_if_instr;
  logic [NUM_EVT-1:0]   i_evt;
  logic [2:0]           i_rd_sel;
  logic [31:0]          o_rd_data;
  logic [NUM_EVT+1:0]   o_ovf, o_ovf_s;
  logic                 o_running, o_done, o_timeout;
  logic [3:0]           o_rd_data_s;
  logic                 o_running_s, o_done_s, o_timeout_s;

  int n_chk = 0, n_fail = 0;
  int exp_cyc, exp_ins;
  int exp_evt[NUM_EVT];
  logic [31:0] exp_q[$];
  logic [3:0]  exp_s_q[$];

  always #5 i_clk = ~i_clk;

  pipe_perf_mon dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_clear(i_clear),
    .i_insn_vld(i_insn_vld), .i_if_instr(i_if_instr), .i_evt(i_evt), .i_rd_sel(i_rd_sel),
    .o_rd_data(o_rd_data), .o_ovf(o_ovf), .o_running(o_running), .o_done(o_done),
    .o_timeout(o_timeout)
  );

  pipe_perf_mon #(.CNT_W(4), .WDOG_CYC(8)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_clear(i_clear),
    .i_insn_vld(i_insn_vld), .i_if_instr(i_if_instr), .i_evt(i_evt), .i_rd_sel(i_rd_sel),
    .o_rd_data(o_rd_data_s), .o_ovf(o_ovf_s), .o_running(o_running_s), .o_done(o_done_s),
    .o_timeout(o_timeout_s)
  );

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  task automatic model_zero;
    exp_cyc = 0; exp_ins = 0;
    for (int k = 0; k < NUM_EVT; k++) exp_evt[k] = 0;
  endtask

  task automatic do_clear;
    i_clear = 1'b1; tick; i_clear = 1'b0; model_zero();
  endtask

  // One cycle of stimulus; 'counted' says whether this cycle should land in the counters.
  task automatic step(input bit vld, input bit [NUM_EVT-1:0] ev, input bit hw, input bit counted);
    i_insn_vld = vld; i_evt = ev; i_if_instr = hw ? HALT : NOP;
    if (counted) begin
      exp_cyc++;
      if (vld) exp_ins++;
      for (int k = 0; k < NUM_EVT; k++) if (ev[k]) exp_evt[k]++;
    end
    tick;
  endtask

  task automatic push_model;
    exp_q.push_back(32'(exp_cyc));
    exp_q.push_back(32'(exp_ins));
    for (int k = 0; k < NUM_EVT; k++) exp_q.push_back(32'(exp_evt[k]));
  endtask

  task automatic test_reset;
    logic [31:0] e;
    i_rst = 1'b1; i_enable = 1'b1; tick; tick;
    i_rst = 1'b0; i_enable = 1'b0;
    model_zero();
    n_chk++; if (o_running !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got run=%b done=%b exp 0 0", o_running, o_done); end
    n_chk++; if (o_ovf !== '0 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf got ovf=%b to=%b exp 0", o_ovf, o_timeout); end
    n_chk++; if (o_rd_data !== '0) begin
      n_fail++; $display("FAIL reset_rd got=%0h exp=0", o_rd_data); end
    push_model();
    for (int s = 0; s < NUM_EVT + 2; s++) begin
      i_rd_sel = 3'(s); tick; e = exp_q.pop_front();
      n_chk++; if (o_rd_data !== e) begin
        n_fail++; $display("FAIL reset_cnt sel=%0d got=%0d exp=%0d", s, o_rd_data, e); end
    end
  endtask

  task automatic test_idle_halt;
    logic [31:0] e;
    do_clear();
    for (int c = 0; c < 5; c++) step(1'b1, '1, 1'b1, 1'b0);
    n_chk++; if (o_running !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL idle_halt_state got run=%b done=%b exp 0 0", o_running, o_done); end
    push_model();
    for (int s = 0; s < NUM_EVT + 2; s++) begin
      i_rd_sel = 3'(s); tick; e = exp_q.pop_front();
      n_chk++; if (o_rd_data !== e) begin
        n_fail++; $display("FAIL idle_halt_cnt sel=%0d got=%0d exp=%0d", s, o_rd_data, e); end
    end
  endtask

  task automatic test_run_drain;
    logic [31:0] e;
    do_clear();
    i_enable = 1'b1; step(1'b1, '1, 1'b0, 1'b0); i_enable = 1'b0;
    for (int c = 1; c <= 20; c++)
      step(c <= 12, {(c >= 10 && c <= 12), 1'b0, 1'b0, (c <= 7)}, c == 20, 1'b1);
    n_chk++; if (o_running !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL drain_enter got run=%b done=%b exp 1 0", o_running, o_done); end
    for (int d = 1; d <= 4; d++) begin
      step(d <= 2, '0, d == 1, 1'b1);
      if (d == 3) begin
        n_chk++; if (o_done !== 1'b0) begin
          n_fail++; $display("FAIL drain_early_done got=%b exp=0", o_done); end
      end
    end
    n_chk++; if (o_done !== 1'b1 || o_running !== 1'b0) begin
      n_fail++; $display("FAIL done_rise got done=%b run=%b exp 1 0", o_done, o_running); end
    i_enable = 1'b1;
    for (int c = 0; c < 100; c++) step(1'b1, '1, 1'b1, 1'b0);
    i_enable = 1'b0; i_insn_vld = 1'b0; i_evt = '0; i_if_instr = NOP;
    n_chk++; if (o_done !== 1'b1 || o_ovf !== '0 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL done_hold got done=%b ovf=%b to=%b exp 1 0 0", o_done, o_ovf, o_timeout); end
    push_model();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    for (int s = 0; s < 8; s++) begin
      i_rd_sel = 3'(s); tick; e = exp_q.pop_front();
      n_chk++; if (o_rd_data !== e) begin
        n_fail++; $display("FAIL run_cnt sel=%0d got=%0d exp=%0d", s, o_rd_data, e); end
    end
  endtask

  task automatic test_clear_on_halt;
    logic [31:0] e;
    do_clear();
    i_enable = 1'b1; step(1'b0, '0, 1'b0, 1'b0); i_enable = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b1, 4'b0101, 1'b0, 1'b1);
    i_clear = 1'b1; step(1'b1, '1, 1'b1, 1'b0); i_clear = 1'b0;
    model_zero();
    n_chk++; if (o_running !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL clear_halt_state got run=%b done=%b exp 0 0", o_running, o_done); end
    for (int c = 0; c < 6; c++) step(1'b1, '1, 1'b0, 1'b0);
    n_chk++; if (o_running !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL clear_no_drain got run=%b done=%b exp 0 0", o_running, o_done); end
    push_model();
    for (int s = 0; s < NUM_EVT + 2; s++) begin
      i_rd_sel = 3'(s); tick; e = exp_q.pop_front();
      n_chk++; if (o_rd_data !== e) begin
        n_fail++; $display("FAIL clear_halt_cnt sel=%0d got=%0d exp=%0d", s, o_rd_data, e); end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] e;
    logic [3:0]  es;
    do_clear();
    i_enable = 1'b1; step(1'b0, '0, 1'b0, 1'b0); i_enable = 1'b0;
    for (int c = 1; c <= 20; c++) step(1'b1, '0, c == 20, 1'b1);
    for (int d = 1; d <= 4; d++) step(1'b1, '0, 1'b0, 1'b1);
    i_insn_vld = 1'b0; i_if_instr = NOP;
    n_chk++; if (o_done !== 1'b1 || o_done_s !== 1'b1) begin
      n_fail++; $display("FAIL sat_done got %b %b exp 1 1", o_done, o_done_s); end
    n_chk++; if (o_ovf_s !== 6'b000011 || o_ovf !== '0) begin
      n_fail++; $display("FAIL sat_ovf got small=%b main=%b exp 000011 000000", o_ovf_s, o_ovf); end
    exp_q.push_back(32'(exp_cyc)); exp_q.push_back(32'(exp_ins));
    exp_s_q.push_back(4'hF); exp_s_q.push_back(4'hF);
    for (int s = 0; s < 2; s++) begin
      i_rd_sel = 3'(s); tick; e = exp_q.pop_front(); es = exp_s_q.pop_front();
      n_chk++; if (o_rd_data !== e) begin
        n_fail++; $display("FAIL sat_main sel=%0d got=%0d exp=%0d", s, o_rd_data, e); end
      n_chk++; if (o_rd_data_s !== es) begin
        n_fail++; $display("FAIL sat_small sel=%0d got=%0h exp=%0h", s, o_rd_data_s, es); end
    end
  endtask

`ifdef PERF_MON_WATCHDOG_EN
  task automatic test_watchdog;
    logic [3:0] es;
    do_clear();
    i_enable = 1'b1; step(1'b0, '0, 1'b0, 1'b0); i_enable = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (c == 7) begin
        n_chk++; if (o_done_s !== 1'b0) begin
          n_fail++; $display("FAIL wdog_early got done=%b exp=0", o_done_s); end
      end
    end
    n_chk++; if (o_done_s !== 1'b1 || o_timeout_s !== 1'b1 || o_running_s !== 1'b0) begin
      n_fail++; $display("FAIL wdog_fire got done=%b to=%b run=%b exp 1 1 0", o_done_s, o_timeout_s, o_running_s); end
    n_chk++; if (o_timeout !== 1'b0 || o_running !== 1'b1) begin
      n_fail++; $display("FAIL wdog_main got to=%b run=%b exp 0 1", o_timeout, o_running); end
    exp_s_q.push_back(4'(exp_cyc));
    i_rd_sel = 3'd0; tick; es = exp_s_q.pop_front();
    n_chk++; if (o_rd_data_s !== es) begin
      n_fail++; $display("FAIL wdog_cycles got=%0d exp=%0d", o_rd_data_s, es); end
  endtask
`endif

  initial begin
    i_rst = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_insn_vld = 1'b0;
    i_if_instr = NOP; i_evt = '0; i_rd_sel = '0;
    model_zero();
    test_reset();
    test_idle_halt();
    test_run_drain();
    test_clear_on_halt();
    test_saturation();
`ifdef PERF_MON_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
